// File: rtl/alu_pkg.sv
// ============================================================================
// Package : alu_pkg
// Brief   : Shared opcode encodings, flag bit positions and FSM state type
//           for the sequential ALU and its multiplier.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Opcode encoding, unchanged from the combinational 4-bit ALU
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_MULH = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  // Bit positions inside the 4-bit flags word
  localparam int F_C  = 0;
  localparam int F_B  = 1;
  localparam int F_Z  = 2;
  localparam int F_LT = 3;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // True for the opcodes that go through the iterative multiplier
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// Module : alu_seq_mul
// Brief  : Iterative shift-add multiplier. One partial product per cycle,
//          LSB-first over the multiplier operand; WIDTH cycles after start.
//          o_prod carries the accumulator value including the current
//          iteration, so it is the finished product while o_done is high.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int              c_cw   = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  logic                 r_run;
  logic [c_cw-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_next;

  // Add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  assign o_done = r_run && (r_cnt == c_last);
  assign o_prod = w_acc_next;

  // Load operands on start, then step one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : Registered ALU with valid/ready handshakes on both sides, internal
//          carry/borrow state for multi-word ADC/SBB chains, barrel shifts
//          and an iterative multiplier for MUL/MULH.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [3:0]       flags
);

  import alu_pkg::*;

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_c;
  logic [3:0]         r_flags;
  logic               r_mul_high;
  logic               r_mul_lt;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_lt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_cy;
  logic               w_bo;
  logic [3:0]         w_flags_next;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [WIDTH-1:0]   w_mul_res;

  assign in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = is_mul_op(mode);
  assign w_lt      = (a < b);
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign flags     = r_flags;

  // Single-cycle datapath; carry/borrow default to their held values
  always_comb begin
    w_sum = '0;
    w_dif = '0;
    w_res = '0;
    w_cy  = r_flags[F_C];
    w_bo  = r_flags[F_B];
    case (mode)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[WIDTH-1:0];
        w_cy  = w_sum[WIDTH];
      end
      OP_ADC: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_flags[F_C]};
        w_res = w_sum[WIDTH-1:0];
        w_cy  = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_dif = {1'b0, a} - {1'b0, b};
        w_res = w_dif[WIDTH-1:0];
        w_bo  = w_dif[WIDTH];
      end
      OP_SBB: begin
        w_dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, r_flags[F_B]};
        w_res = w_dif[WIDTH-1:0];
        w_bo  = w_dif[WIDTH];
      end
      OP_SHL:  w_res = a << b[SHW-1:0];
      OP_SHR:  w_res = a >> b[SHW-1:0];
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_NOT:  w_res = ~a;
      OP_XOR:  w_res = a ^ b;
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_CMP: begin
        w_dif = {1'b0, a} - {1'b0, b};
        w_res = a;
        w_bo  = w_dif[WIDTH];
      end
      OP_RSVD: w_res = '0;
      default: w_res = '0;
    endcase
  end

  // Assemble the flags word for a single-cycle result
  always_comb begin
    w_flags_next       = '0;
    w_flags_next[F_C]  = w_cy;
    w_flags_next[F_B]  = w_bo;
    w_flags_next[F_Z]  = (w_res == '0);
    w_flags_next[F_LT] = w_lt;
  end

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_mul),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  assign w_mul_res = r_mul_high ? w_mul_prod[2*WIDTH-1:WIDTH] : w_mul_prod[WIDTH-1:0];

  // Control FSM with registered result/flags; flag_clr overrides C/B last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_flags     <= '0;
      r_mul_high  <= 1'b0;
      r_mul_lt    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_is_mul) begin
          // LT is captured now because operands may change while busy
          r_state     <= BUSY;
          r_out_valid <= 1'b0;
          r_mul_high  <= (mode == OP_MULH);
          r_mul_lt    <= w_lt;
        end else begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
          r_c         <= w_res;
          r_flags     <= w_flags_next;
        end
      end else if (r_state == BUSY) begin
        if (w_mul_done) begin
          r_state        <= HOLD;
          r_out_valid    <= 1'b1;
          r_c            <= w_mul_res;
          r_flags[F_Z]   <= (w_mul_res == '0);
          r_flags[F_LT]  <= r_mul_lt;
        end
      end else if ((r_state == HOLD) && out_ready) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
      end
      if (flag_clr) begin
        r_flags[F_C] <= 1'b0;
        r_flags[F_B] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
